// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one round per clock with an on-the-fly
// key schedule. The forward schedule walks K0..K10, then rounds run from K10
// back down to K0 using the inverse schedule.
// Optional build macro KEY_CACHE_EN: remembers the last cipher key and its K10
// so that a repeated key skips the forward key expansion.
module aes_inv_cipher_iter #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned OUT_HOLD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cipher_text_128,
  input  logic [DATA_W-1:0] cipher_key_128,
  input  logic              valid_in,
  output logic [DATA_W-1:0] plan_text_128,
  output logic              valid_out,
  output logic              busy
);

  if (DATA_W != 128) begin : g_width_check
    $error("aes_inv_cipher_iter: DATA_W must be 128");
  end

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ADDK, S_ROUND} state_e;

  state_e       state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] pt_q, pt_d;
  logic         vout_q, vout_d;
`ifdef KEY_CACHE_EN
  logic [127:0] ck_key_q, ck_key_d;
  logic [127:0] ck_k10_q, ck_k10_d;
  logic         ck_vld_q, ck_vld_d;
`endif

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sw_in, sw_out;
  logic [127:0] key_fwd, key_inv, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'h8d : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 by repeated squaring; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int unsigned i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    int unsigned  src;
    t = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      src = 4 * (((i / 4) + 4 - (i % 4)) % 4) + (i % 4);
      t[127-8*i -: 8] = inv_sbox(s[127-8*src -: 8]);
    end
    t = t ^ rk;
    if (!last) begin
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        t[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        t[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        t[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        t[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
    end
    return t;
  endfunction

  // Key schedule step in both directions; one SubWord is shared because
  // KEYEXP and ROUND never overlap. Inverse recovers w3 of Kr-1 as w3^w2 first.
  always_comb begin
    w0      = key_q[127:96];
    w1      = key_q[95:64];
    w2      = key_q[63:32];
    w3      = key_q[31:0];
    sw_in   = (state_q == S_KEYEXP) ? {w3[23:0], w3[31:24]}
                                    : {(w3 ^ w2) & 32'hffffff, 8'h00} | {24'h0, (w3[31:24] ^ w2[31:24])};
    sw_out  = sub_word(sw_in);
    key_fwd[127:96] = w0 ^ sw_out ^ {rcon_q, 24'h0};
    key_fwd[95:64]  = key_fwd[127:96] ^ w1;
    key_fwd[63:32]  = key_fwd[95:64] ^ w2;
    key_fwd[31:0]   = key_fwd[63:32] ^ w3;
    key_inv[31:0]   = w3 ^ w2;
    key_inv[63:32]  = w2 ^ w1;
    key_inv[95:64]  = w1 ^ w0;
    key_inv[127:96] = w0 ^ sw_out ^ {rcon_q, 24'h0};
    round_out = inv_round(blk_q, key_inv, cnt_q == 4'd1);
  end

  // Next-state logic for the FSM and the datapath registers
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    vout_d  = 1'b0;
`ifdef KEY_CACHE_EN
    ck_key_d = ck_key_q;
    ck_k10_d = ck_k10_q;
    ck_vld_d = ck_vld_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          blk_d = cipher_text_128;
          cnt_d = '0;
`ifdef KEY_CACHE_EN
          if (ck_vld_q && (cipher_key_128 == ck_key_q)) begin
            // rcon parked one forward step past 0x36, as after a full expansion
            key_d   = ck_k10_q;
            rcon_d  = 8'h6c;
            state_d = S_ADDK;
          end else begin
            key_d    = cipher_key_128;
            rcon_d   = 8'h01;
            ck_key_d = cipher_key_128;
            ck_vld_d = 1'b0;
            state_d  = S_KEYEXP;
          end
`else
          key_d   = cipher_key_128;
          rcon_d  = 8'h01;
          state_d = S_KEYEXP;
`endif
        end
      end
      S_KEYEXP: begin
        key_d  = key_fwd;
        rcon_d = xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = S_ADDK;
`ifdef KEY_CACHE_EN
          ck_k10_d = key_fwd;
          ck_vld_d = 1'b1;
`endif
        end
      end
      S_ADDK: begin
        blk_d   = blk_q ^ key_q;
        rcon_d  = inv_xtime(rcon_q);
        cnt_d   = 4'd10;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        key_d  = key_inv;
        rcon_d = inv_xtime(rcon_q);
        blk_d  = round_out;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          pt_d    = round_out;
          vout_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath, key, round and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q  <= '0;
      key_q  <= '0;
      rcon_q <= '0;
      cnt_q  <= '0;
      pt_q   <= '0;
      vout_q <= 1'b0;
`ifdef KEY_CACHE_EN
      ck_key_q <= '0;
      ck_k10_q <= '0;
      ck_vld_q <= 1'b0;
`endif
    end else begin
      blk_q  <= blk_d;
      key_q  <= key_d;
      rcon_q <= rcon_d;
      cnt_q  <= cnt_d;
      pt_q   <= pt_d;
      vout_q <= vout_d;
`ifdef KEY_CACHE_EN
      ck_key_q <= ck_key_d;
      ck_k10_q <= ck_k10_d;
      ck_vld_q <= ck_vld_d;
`endif
    end
  end

  assign valid_out     = vout_q;
  assign busy          = (state_q != S_IDLE);
  assign plan_text_128 = (OUT_HOLD != 0) ? pt_q : (vout_q ? pt_q : '0);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors. Two instances
// share the inputs: one holding the last result, one zeroing it between pulses.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ct, key;
  logic         valid_in;
  logic [127:0] pt1, pt0;
  logic         vo1, vo0, busy1, busy0;

  int checks = 0;
  int errors = 0;

  logic [127:0] c1_key, c1_ct, c1_pt, b_key, b_ct, b_pt;

`ifdef KEY_CACHE_EN
  localparam int REPEAT_LAT = 11;
`else
  localparam int REPEAT_LAT = 21;
`endif

  aes_inv_cipher_iter #(.DATA_W(128), .OUT_HOLD(1)) dut (
    .clk(clk), .reset(reset), .cipher_text_128(ct), .cipher_key_128(key),
    .valid_in(valid_in), .plan_text_128(pt1), .valid_out(vo1), .busy(busy1)
  );

  aes_inv_cipher_iter #(.DATA_W(128), .OUT_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .cipher_text_128(ct), .cipher_key_128(key),
    .valid_in(valid_in), .plan_text_128(pt0), .valid_out(vo0), .busy(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present a request for the next rising edge (accept edge E0), then drop valid_in
  task automatic send(input logic [127:0] c, input logic [127:0] k);
    ct       = c;
    key      = k;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Wait for the result pulse; returns at the falling edge where valid_out is seen
  task automatic wait_result(input string name, input int exp_lat, input logic [127:0] exp_pt);
    int  lat;
    int  busy_cnt;
    bit  seen;
    seen = 1'b0;
    busy_cnt = 0;
    lat = -1;
    for (int k = 0; k <= exp_lat + 4 && !seen; k++) begin
      @(negedge clk);
      if (busy1) busy_cnt++;
      if (vo1) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        checks++;
        if (pt0 !== '0) begin
          errors++;
          $display("FAIL %s_hold0_zero: cycle %0d got %h want 0", name, k, pt0);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no valid_out within %0d cycles", name, exp_lat + 4);
    end else begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (pt1 !== exp_pt) begin
        errors++;
        $display("FAIL %s_pt: got %h want %h", name, pt1, exp_pt);
      end
      checks++;
      if (vo0 !== 1'b1 || pt0 !== exp_pt) begin
        errors++;
        $display("FAIL %s_pt_hold0: got vo=%b pt=%h want vo=1 pt=%h", name, vo0, pt0, exp_pt);
      end
      checks++;
      if (busy_cnt != exp_lat) begin
        errors++;
        $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, exp_lat);
      end
    end
  endtask

  // No further valid_out pulses over n cycles
  task automatic expect_quiet(input string name, input int n);
    int extra;
    extra = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (vo1 || vo0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s_quiet: got %0d extra pulses want 0", name, extra);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid_in = 1'b0;
    ct = '0;
    key = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vo1, busy1, vo0, busy0} !== 4'b0000 || pt1 !== '0 || pt0 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got vo=%b busy=%b pt=%h want all 0", vo1, busy1, pt1);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || vo1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b vo=%b want 0 0", busy1, vo1);
    end
  endtask

  task automatic test_fips_c1();
    send(c1_ct, c1_key);
    wait_result("c1", 21, c1_pt);
    expect_quiet("c1", 5);
  endtask

  task automatic test_fips_b();
    send(b_ct, b_key);
    wait_result("b", 21, b_pt);
    expect_quiet("b", 5);
  endtask

  task automatic test_ignore_busy();
    @(negedge clk);
    send(c1_ct, c1_key);
    repeat (4) @(posedge clk);
    #1;
    ct = b_ct;
    key = b_key;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    wait_result("ignore", 6, c1_pt);
    expect_quiet("ignore", 30);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    send(c1_ct, c1_key);
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({vo1, busy1, vo0, busy0} !== 4'b0000 || pt1 !== '0 || pt0 !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got vo=%b busy=%b pt=%h want all 0", vo1, busy1, pt1);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    expect_quiet("midreset", 30);
    send(b_ct, b_key);
    wait_result("after_reset_b", 21, b_pt);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    send(c1_ct, c1_key);
    wait_result("b2b_first", 21, c1_pt);
    send(c1_ct, c1_key);
    wait_result("b2b_second", REPEAT_LAT, c1_pt);
  endtask

  task automatic test_out_hold();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (vo1 !== 1'b0 || pt1 !== c1_pt || pt0 !== '0) begin
        errors++;
        $display("FAIL out_hold: cycle %0d got vo=%b pt1=%h pt0=%h want vo=0 pt1=%h pt0=0",
                 k, vo1, pt1, pt0, c1_pt);
      end
    end
  endtask

  initial begin
    c1_key = 128'h000102030405060708090a0b0c0d0e0f;
    c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    c1_pt  = 128'h00112233445566778899aabbccddeeff;
    b_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    b_ct   = 128'h3925841d02dc09fbdc118597196a0b32;
    b_pt   = 128'h3243f6a8885a308d313198a2e0370734;
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_ignore_busy();
    test_reset_midop();
    test_back_to_back();
    test_out_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
